// File: rtl/ext_pkg.sv
// ext_pkg: op codes, FIFO entry layout and parameter checks for ext_pipe.
// Op 111 (EXT_BROFF) is a branch offset only when EXT_BROFF_EN is defined.
package ext_pkg;

  localparam logic [2:0] EXT_ZERO  = 3'b000;
  localparam logic [2:0] EXT_LUI   = 3'b001;
  localparam logic [2:0] EXT_SIGN  = 3'b010;
  localparam logic [2:0] EXT_LB    = 3'b011;
  localparam logic [2:0] EXT_LBU   = 3'b100;
  localparam logic [2:0] EXT_LH    = 3'b101;
  localparam logic [2:0] EXT_LHU   = 3'b110;
  localparam logic [2:0] EXT_BROFF = 3'b111;

  localparam int EXT_MIN_DATA_W = 16;
  localparam int EXT_MIN_DEPTH  = 1;
  localparam int EXT_MAX_DEPTH  = 4;
  localparam int EXT_DEF_DATA_W = 32;
  localparam int EXT_DEF_TAG_W  = 5;

  // Entry layout at the default widths; ext_pipe keeps the
  // same field order for its own parameterised widths.
  typedef struct packed {
    logic [EXT_DEF_DATA_W-1:0] data;
    logic [EXT_DEF_TAG_W-1:0]  tag;
    logic                      err;
  } ext_ent_t;

  function automatic bit ext_cfg_ok(
    input int data_w,
    input int imm_w,
    input int depth
  );
    return (data_w >= EXT_MIN_DATA_W)
        && (data_w % 2 == 0)
        && (imm_w >= 1)
        && (imm_w <= data_w)
        && (depth >= EXT_MIN_DEPTH)
        && (depth <= EXT_MAX_DEPTH);
  endfunction

endpackage

// File: rtl/ext_core.sv
// ext_core: combinational immediate / load-lane extension.
// Op 111 is a branch offset with EXT_BROFF_EN, otherwise illegal.
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        off,
  output logic [DATA_W-1:0] res,
  output logic              err
);

  logic [IMM_W-1:0] imm;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;

  assign imm    = IMM_W'(data);
  assign lane_b = 8'(data >> {off, 3'b000});
  assign lane_h = 16'(data >> {off[1], 4'b0000});

  // Select the extension for the requested op; misaligned
  // halves and unsupported ops yield zero data with err set.
  always_comb begin
    res = '0;
    err = 1'b0;
    unique case (op)
      EXT_ZERO: res = DATA_W'(imm);
      EXT_LUI:  res = DATA_W'(imm) << (DATA_W - IMM_W);
      EXT_SIGN: res = DATA_W'($signed(imm));
      EXT_LB:   res = DATA_W'($signed(lane_b));
      EXT_LBU:  res = DATA_W'(lane_b);
      EXT_LH: begin
        if (off[0]) err = 1'b1;
        else        res = DATA_W'($signed(lane_h));
      end
      EXT_LHU: begin
        if (off[0]) err = 1'b1;
        else        res = DATA_W'(lane_h);
      end
      EXT_BROFF: begin
`ifdef EXT_BROFF_EN
        res = DATA_W'($signed(imm)) << 2;
`else
        err = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: registered extension unit with valid/ready and output FIFO.
// EXT_BROFF_EN enables op 111 as a branch offset in ext_core.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_op,
  input  logic [1:0]        in_off,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (!ext_cfg_ok(DATA_W, IMM_W, DEPTH)) begin : g_bad_cfg
    $error("ext_pipe: unsupported parameter set");
  end

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } ent_t;

  ent_t              mem [DEPTH];
  ent_t              head;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] res;
  logic              err;
  logic              push;
  logic              pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  ext_core #(
    .DATA_W(DATA_W),
    .IMM_W (IMM_W)
  ) u_core (
    .op  (in_op),
    .data(in_data),
    .off (in_off),
    .res (res),
    .err (err)
  );

  // in_ready looks only at registered count, never at out_ready.
  assign in_ready  = reset && !flush && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  assign head     = out_valid ? mem[rd_ptr] : '0;
  assign out_data = head.data;
  assign out_tag  = head.tag;
  assign out_err  = head.err;

  // Pointer and occupancy bookkeeping; flush empties the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Capture the extended result at the tail on each accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{data: res, tag: in_tag, err: err};
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed vector table plus handshake, flush, reset sequences.
// Op 111 expectations follow EXT_BROFF_EN.
module tb_ext_pipe;
  import ext_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [2:0]  in_op = '0;
  logic [1:0]  in_off = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ext_pipe #(
    .DATA_W(32),
    .IMM_W (16),
    .DEPTH (2),
    .TAG_W (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_op    (in_op),
    .in_off   (in_off),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_err  (out_err)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] data;
    logic [1:0]  off;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [2:0] op,
                        input logic [31:0] d, input logic [1:0] off,
                        input logic [4:0] tag);
    in_valid = v;
    in_op    = op;
    in_data  = d;
    in_off   = off;
    in_tag   = tag;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_data"},  out_data,       32'd0);
    chk({nm, "_tag"},   32'(out_tag),   32'd0);
    chk({nm, "_err"},   32'(out_err),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] got [$];
    bit         sent;

    vt[0]  = '{EXT_ZERO,  32'h0000_8001, 2'd0, 32'h0000_8001, 1'b0};
    vt[1]  = '{EXT_LUI,   32'h0000_8001, 2'd0, 32'h8001_0000, 1'b0};
    vt[2]  = '{EXT_SIGN,  32'h0000_8001, 2'd0, 32'hFFFF_8001, 1'b0};
    vt[3]  = '{EXT_LB,    32'h80F0_7F81, 2'd0, 32'hFFFF_FF81, 1'b0};
    vt[4]  = '{EXT_LB,    32'h80F0_7F81, 2'd1, 32'h0000_007F, 1'b0};
    vt[5]  = '{EXT_LB,    32'h80F0_7F81, 2'd2, 32'hFFFF_FFF0, 1'b0};
    vt[6]  = '{EXT_LB,    32'h80F0_7F81, 2'd3, 32'hFFFF_FF80, 1'b0};
    vt[7]  = '{EXT_LBU,   32'h80F0_7F81, 2'd3, 32'h0000_0080, 1'b0};
    vt[8]  = '{EXT_LHU,   32'h80F0_7F81, 2'd2, 32'h0000_80F0, 1'b0};
    vt[9]  = '{EXT_LH,    32'h80F0_7F81, 2'd2, 32'hFFFF_80F0, 1'b0};
    vt[10] = '{EXT_LH,    32'h80F0_7F81, 2'd0, 32'h0000_7F81, 1'b0};
    vt[11] = '{EXT_LH,    32'h80F0_7F81, 2'd1, 32'h0000_0000, 1'b1};
    vt[12] = '{EXT_LHU,   32'h80F0_7F81, 2'd3, 32'h0000_0000, 1'b1};
    vt[13] = '{EXT_ZERO,  32'hABCD_8001, 2'd0, 32'h0000_8001, 1'b0};
    vt[14] = '{EXT_SIGN,  32'hABCD_7FFF, 2'd0, 32'h0000_7FFF, 1'b0};
`ifdef EXT_BROFF_EN
    vt[15] = '{EXT_BROFF, 32'h0000_FFFF, 2'd0, 32'hFFFF_FFFC, 1'b0};
    vt[16] = '{EXT_BROFF, 32'h0000_1234, 2'd0, 32'h0000_48D0, 1'b0};
`else
    vt[15] = '{EXT_BROFF, 32'h0000_FFFF, 2'd0, 32'h0000_0000, 1'b1};
    vt[16] = '{EXT_BROFF, 32'h0000_1234, 2'd0, 32'h0000_0000, 1'b1};
`endif

    // reset state
    #2;
    chk_idle("rst");
    chk("rst_ready", 32'(in_ready), 32'd0);
    #20;
    reset = 1'b1;
    #1;
    chk("rst_rel_ready", 32'(in_ready), 32'd1);
    tick;

    // vector table, one op at a time into an empty FIFO
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      set_in(1'b1, vt[i].op, vt[i].data, vt[i].off, 5'(i));
      #1;
      chk("vec_ready", 32'(in_ready), 32'd1);
      chk("vec_pre_valid", 32'(out_valid), 32'd0);
      tick;
      in_valid = 1'b0;
      chk("vec_valid", 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), out_data, vt[i].exp);
      chk($sformatf("vec%0d_err", i), 32'(out_err), 32'(vt[i].err));
      chk($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(i));
      tick;
      chk_idle("vec_drained");
    end

    // back-pressure: fill, hold third, then drain in order
    out_ready = 1'b0;
    set_in(1'b1, EXT_ZERO, 32'd1, 2'd0, 5'd1);
    #1 chk("bp_ready1", 32'(in_ready), 32'd1);
    tick;
    set_in(1'b1, EXT_ZERO, 32'd2, 2'd0, 5'd2);
    #1 chk("bp_ready2", 32'(in_ready), 32'd1);
    tick;
    set_in(1'b1, EXT_ZERO, 32'd3, 2'd0, 5'd3);
    #1 chk("bp_full_ready", 32'(in_ready), 32'd0);
    tick;
    chk("bp_hold_tag", 32'(out_tag), 32'd1);
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1 chk("bp_full_blocks", 32'(in_ready), 32'd0);
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      if (out_valid) begin
        got.push_back(out_tag);
        chk("bp_data", out_data, 32'(out_tag));
      end
      sent = in_valid && in_ready;
      tick;
      if (sent) in_valid = 1'b0;
    end
    chk("bp_count", 32'(got.size()), 32'd3);
    for (int k = 0; k < got.size(); k++)
      chk($sformatf("bp_order%0d", k), 32'(got[k]), 32'(k + 1));
    #1 chk_idle("bp_empty");

    // steady stream: one result per cycle, no bubbles
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_in(1'b1, EXT_ZERO, 32'(k + 16), 2'd0, 5'(k + 16));
      #1 chk("st_ready", 32'(in_ready), 32'd1);
      if (k > 0) begin
        chk("st_valid", 32'(out_valid), 32'd1);
        chk("st_tag", 32'(out_tag), 32'(k + 15));
      end
      tick;
    end
    in_valid = 1'b0;
    chk("st_last_tag", 32'(out_tag), 32'd23);
    tick;
    chk_idle("st_empty");

    // flush with two entries and an input pending
    out_ready = 1'b0;
    set_in(1'b1, EXT_SIGN, 32'h0000_8000, 2'd0, 5'd10);
    tick;
    set_in(1'b1, EXT_SIGN, 32'h0000_8000, 2'd0, 5'd11);
    tick;
    set_in(1'b1, EXT_SIGN, 32'h0000_8000, 2'd0, 5'd12);
    flush = 1'b1;
    #1;
    chk("fl_ready", 32'(in_ready), 32'd0);
    chk("fl_pre_valid", 32'(out_valid), 32'd1);
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_idle("fl_after");
    #1 chk("fl_ready_after", 32'(in_ready), 32'd1);
    tick;
    chk_idle("fl_no_deliver");

    // asynchronous reset mid-stream, off the clock edge
    set_in(1'b1, EXT_ZERO, 32'h0000_1234, 2'd0, 5'd5);
    tick;
    in_valid = 1'b0;
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk_idle("ar_now");
    chk("ar_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #2;
    chk_idle("ar_held");
    #4 reset = 1'b1;
    #1 chk("ar_rel_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    set_in(1'b1, EXT_BROFF, 32'h0000_FFFF, 2'd0, 5'd7);
    tick;
    in_valid = 1'b0;
    chk("ar_op7_valid", 32'(out_valid), 32'd1);
    chk("ar_op7_tag", 32'(out_tag), 32'd7);
`ifdef EXT_BROFF_EN
    chk("ar_op7_data", out_data, 32'hFFFF_FFFC);
    chk("ar_op7_err", 32'(out_err), 32'd0);
`else
    chk("ar_op7_data", out_data, 32'h0000_0000);
    chk("ar_op7_err", 32'(out_err), 32'd1);
`endif
    tick;
    chk_idle("ar_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Registered, parametrised immediate/load-data extension unit for the MIPS pipeline.
- Covers immediate modes (zero, LUI, sign, optional branch offset) and load-data modes (LB/LBU/LH/LHU with byte offset).
- Sits between ID/MEM producers and consumers.
- Decouples them with a valid/ready handshake and a small output FIFO.

Parameters:
- DATA_W, 32, datapath/output width; even, >= 2*IMM_W/... at minimum 16.
- IMM_W, 16, immediate field width taken from in_data[IMM_W-1:0]; IMM_W <= DATA_W.
- DEPTH, 2, output FIFO entries, 1..4.
- TAG_W, 5, sideband tag (e.g. destination register), carried unmodified.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush; empties the FIFO.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit can accept an input this cycle.
- in_data  in  DATA_W  immediate (low IMM_W bits) or loaded word.
- in_op  in  3  operation select.
- in_off  in  2  byte offset for load modes (addr[1:0]).
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- out_data  out  DATA_W  extended result.
- out_tag  out  TAG_W  tag of head entry.
- out_err  out  1  head entry is an illegal op or misaligned access.

Behaviour:
- Ops (in_op):
  - 000 ZERO: zero-extend imm.
  - 001 LUI: imm placed at bits [DATA_W-1:DATA_W-IMM_W], rest 0.
  - 010 SIGN: sign-extend imm.
  - 011 LB: sign-extend byte in_data[8*off+7:8*off].
  - 100 LBU: zero-extend that byte.
  - 101 LH: sign-extend half selected by off[1].
  - 110 LHU: zero-extend that half.
  - 111 BROFF: optional feature only.
- Byte/half lanes are little-endian; off 0 selects bits [7:0].
- LH/LHU with off[0]=1: out_data = 0, out_err = 1.
- Accept rule: input accepted when in_valid && in_ready at a rising edge.
- The result is computed combinationally and written to the FIFO tail at that edge.
  - Latency: an accepted op is visible on out_* in the next cycle if the FIFO was empty.
- in_ready = (count < DEPTH) && !flush; registered count only, no combinational path from out_ready.
- Pop rule: pop when out_valid && out_ready.
  - Simultaneous push and pop with 0 < count < DEPTH: count unchanged, order preserved.
  - Full FIFO blocks push even if pop occurs in the same cycle.
- out_valid = (count != 0).
  - When empty, out_data/out_tag/out_err are 0, not stale values.
- FIFO is a circular buffer; read/write pointers wrap modulo DEPTH; count is 0..DEPTH.
- flush (sync):
  - At the edge, count, read pointer and write pointer go to 0.
  - Same-cycle push and pop are discarded.
  - out_valid = 0 the next cycle.
- Reset (async, reset=0):
  - count/pointers cleared immediately; out_valid=0, out_data=0, out_tag=0, out_err=0, in_ready=0 while asserted.
  - Ops mid-flight are lost.
  - After release, in_ready=1 in the first cycle.

Optional Feature:
- Macro: EXT_BROFF_EN.
- Defined: op 111 = sign-extended imm shifted left 2 (branch offset), out_err=0.
- Undefined: op 111 illegal; out_data=0, out_err=1, still pushed and popped normally.

Decomposition:
- Package ext_pkg holds:
  - op localparams (EXT_ZERO, EXT_LUI, EXT_SIGN, EXT_LB, EXT_LBU, EXT_LH, EXT_LHU, EXT_BROFF);
  - the entry struct {data, tag, err};
  - the width-check constants.
- Sub-module ext_core: purely combinational op/lane decode producing {data, err}.
- ext_pipe wraps ext_core with the FIFO and handshake logic.

Test Plan:
- in_data=0x0000_8001, each op ZERO/LUI/SIGN, off=0 -> out_data 0x0000_8001 / 0x8001_0000 / 0xFFFF_8001, out_err=0; each result appears 1 cycle after accept.
- in_data=0x80F0_7F81; LB off 0..3 -> 0xFFFF_FF81, 0x0000_007F, 0xFFFF_FFF0, 0xFFFF_FF80; LHU off=2 -> 0x0000_80F0; LH off=1 -> out_data 0, out_err=1.
- DEPTH=2, out_ready=0, push 3 ops back-to-back -> in_ready falls after 2nd accept, 3rd held; then raise out_ready -> results drain in order with tags 1,2,3.
- Steady stream with out_ready=1 and in_valid=1 every cycle -> one result per cycle, count stays at 1, no bubbles.
- flush asserted with count=2 and in_valid=1 -> next cycle out_valid=0, count=0, flushed input not delivered.
- reset pulled low mid-stream for a non-clock-aligned interval -> outputs 0 immediately; after release, op 111 imm=0xFFFF gives 0xFFFF_FFFC with EXT_BROFF_EN, or out_data=0 and out_err=1 without it.
